// File: rtl/branch_resolve_ctrl_if.sv
// Bundle of decode, operand-forwarding, evaluator and fetch-redirect signals
// for the branch resolve controller.
//
// Handshake: a branch transfers on a rising edge where br_valid & br_ready
// are both high; br_bf/br_pc/br_offset must be stable while br_valid is high,
// and br_ready never depends on br_valid (it is a function of state and kill).
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             br_valid;
  logic             br_ready;
  logic [3:0]       br_bf;
  logic [31:0]      br_pc;
  logic [31:0]      br_offset;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic             rs_ready;
  logic             rt_ready;
  logic             kill;
  logic [31:0]      bce_a;
  logic [31:0]      bce_b;
  logic [3:0]       bce_bf;
  logic             bcres;
  logic             stall;
  logic             resolve_valid;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             err_illegal_bf;
  logic             err_timeout;
  logic [CNT_W-1:0] br_total;
  logic [CNT_W-1:0] br_taken;
  logic [1:0]       dbg_state;

  // Environment side: decode, forwarding network, evaluator and fetch.
  modport master (
    output br_valid, br_bf, br_pc, br_offset, rs_val, rt_val, rs_ready,
           rt_ready, kill, bcres,
    input  br_ready, bce_a, bce_b, bce_bf, stall, resolve_valid,
           redirect_valid, redirect_pc, flush, err_illegal_bf, err_timeout,
           br_total, br_taken, dbg_state
  );

  // Controller side.
  modport slave (
    input  br_valid, br_bf, br_pc, br_offset, rs_val, rt_val, rs_ready,
           rt_ready, kill, bcres,
    output br_ready, bce_a, bce_b, bce_bf, stall, resolve_valid,
           redirect_valid, redirect_pc, flush, err_illegal_bf, err_timeout,
           br_total, br_taken, dbg_state
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: accepts one conditional branch at a time, waits
// for forwarded operands, feeds registered operands to the external
// combinational condition evaluator, then issues a one-cycle resolve /
// redirect / flush pulse. Keeps saturating statistics and sticky errors.
module branch_resolve_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 15
) (
  input logic                 clk,
  input logic                 rst,
  branch_resolve_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    EVAL     = 2'd2
  } state_t;

  localparam int WCNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  state_t             state;
  state_t             state_nx;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [31:0]        pc_q;
  logic [31:0]        off_q;
  logic [31:0]        bce_a_q;
  logic [31:0]        bce_b_q;
  logic [3:0]         bce_bf_q;
  logic               resolve_q;
  logic               redirect_q;
  logic [31:0]        redirect_pc_q;
  logic               err_illegal_q;
  logic               err_timeout_q;
  logic [CNT_W-1:0]   total_q;
  logic [CNT_W-1:0]   taken_q;

  logic               accept;
  logic               bf_legal;
  logic               need_rt;
  logic               ops_ready;
  logic               wait_expired;
  logic [31:0]        target;

  // Decode of the incoming function code, operand needs and branch target.
  always_comb begin
    bf_legal = 1'b0;
    case (bus.br_bf)
      4'b0010, 4'b0011, 4'b1000, 4'b1010, 4'b1100, 4'b1110: bf_legal = 1'b1;
      default: bf_legal = 1'b0;
    endcase
    // Only the two-operand compares (eq / ne) wait for rt.
    need_rt      = (bce_bf_q == 4'b1000) || (bce_bf_q == 4'b1010);
    ops_ready    = bus.rs_ready & (bus.rt_ready | ~need_rt);
    wait_expired = (wait_cnt == WCNT_W'(WAIT_LIMIT - 1));
    accept       = bus.br_valid & bus.br_ready;
    target       = pc_q + 32'd4 + {off_q[29:0], 2'b00};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; kill overrides every transition.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (accept && bf_legal) state_nx = WAIT_OPS;
      WAIT_OPS: begin
        if (ops_ready)         state_nx = EVAL;
        else if (wait_expired) state_nx = IDLE;
      end
      EVAL:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (bus.kill) state_nx = IDLE;
  end

  // Datapath, pulses, statistics and sticky flags; kill freezes all of it
  // except the pulses, which drop back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt      <= '0;
      pc_q          <= '0;
      off_q         <= '0;
      bce_a_q       <= '0;
      bce_b_q       <= '0;
      bce_bf_q      <= '0;
      resolve_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      total_q       <= '0;
      taken_q       <= '0;
    end else begin
      resolve_q  <= 1'b0;
      redirect_q <= 1'b0;
      if (!bus.kill) begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (bf_legal) begin
                bce_bf_q <= bus.br_bf;
                pc_q     <= bus.br_pc;
                off_q    <= bus.br_offset;
                wait_cnt <= '0;
              end else begin
                err_illegal_q <= 1'b1;
              end
            end
          end
          WAIT_OPS: begin
            if (ops_ready) begin
              bce_a_q <= bus.rs_val;
              bce_b_q <= need_rt ? bus.rt_val : 32'd0;
            end else if (wait_expired) begin
              err_timeout_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          EVAL: begin
            resolve_q  <= 1'b1;
            redirect_q <= bus.bcres;
            if (bus.bcres) redirect_pc_q <= target;
            if (total_q != '1) total_q <= total_q + 1'b1;
            if (bus.bcres && (taken_q != '1)) taken_q <= taken_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.br_ready       = (state == IDLE) & ~bus.kill;
  assign bus.stall          = (state != IDLE);
  assign bus.bce_a          = bce_a_q;
  assign bus.bce_b          = bce_b_q;
  assign bus.bce_bf         = bce_bf_q;
  assign bus.resolve_valid  = resolve_q;
  assign bus.redirect_valid = redirect_q;
  assign bus.flush          = redirect_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.err_illegal_bf = err_illegal_q;
  assign bus.err_timeout    = err_timeout_q;
  assign bus.br_total       = total_q;
  assign bus.br_taken       = taken_q;
  assign bus.dbg_state      = state;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Testbench for branch_resolve_ctrl: directed scenarios plus randomized
// branches against a transaction-level model; a second instance with 2-bit
// counters mirrors the same stimulus to observe saturation.
module tb_branch_resolve_ctrl;

  localparam int WAIT_LIMIT = 15;

  logic clk;
  logic rst;

  branch_resolve_ctrl_if #(.CNT_W(16)) bus ();
  branch_resolve_ctrl_if #(.CNT_W(2))  sat_bus ();

  branch_resolve_ctrl #(.CNT_W(16), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  branch_resolve_ctrl #(.CNT_W(2), .WAIT_LIMIT(WAIT_LIMIT)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- evaluator model ----------------
  function automatic logic eval_bc(input logic [3:0] bf, input logic [31:0] a,
                                   input logic [31:0] b);
    case (bf)
      4'b1000: return a == b;
      4'b1010: return a != b;
      4'b1100: return $signed(a) <= 0;
      4'b1110: return $signed(a) > 0;
      4'b0010: return $signed(a) < 0;
      4'b0011: return $signed(a) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  assign bus.bcres = eval_bc(bus.bce_bf, bus.bce_a, bus.bce_b);

  assign sat_bus.br_valid  = bus.br_valid;
  assign sat_bus.br_bf     = bus.br_bf;
  assign sat_bus.br_pc     = bus.br_pc;
  assign sat_bus.br_offset = bus.br_offset;
  assign sat_bus.rs_val    = bus.rs_val;
  assign sat_bus.rt_val    = bus.rt_val;
  assign sat_bus.rs_ready  = bus.rs_ready;
  assign sat_bus.rt_ready  = bus.rt_ready;
  assign sat_bus.kill      = bus.kill;
  assign sat_bus.bcres     = eval_bc(sat_bus.bce_bf, sat_bus.bce_a, sat_bus.bce_b);

  // ---------------- scoreboard ----------------
  int          n_vec;
  int          n_err;
  logic [32:0] exp_q[$];      // {taken, target} per expected resolve
  logic [32:0] mon_e;

  int          m_total;
  int          m_taken;
  logic        m_err_ill;
  logic        m_err_to;
  logic [31:0] m_pc;

  logic [3:0]  legal_bf[6]   = '{4'b0010, 4'b0011, 4'b1000, 4'b1010, 4'b1100, 4'b1110};
  logic [3:0]  illegal_bf[10] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0110,
                                  4'b0111, 4'b1001, 4'b1011, 4'b1101, 4'b1111};

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Pulse monitor: every resolve must match the oldest expected transaction.
  always @(negedge clk) begin
    if (!rst && bus.resolve_valid) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_pulse", 64'(bus.resolve_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("redirect_valid", 64'(bus.redirect_valid), 64'(mon_e[32]));
        check_val("flush", 64'(bus.flush), 64'(mon_e[32]));
        if (mon_e[32]) check_val("redirect_pc", 64'(bus.redirect_pc), 64'(mon_e[31:0]));
      end
    end
  end

  // ---------------- common checks ----------------
  task automatic check_stats(input string tag);
    check_val({tag, "_total"},     64'(bus.br_total), 64'(m_total));
    check_val({tag, "_taken"},     64'(bus.br_taken), 64'(m_taken));
    check_val({tag, "_sat_total"}, 64'(sat_bus.br_total), 64'(sat3(m_total)));
    check_val({tag, "_sat_taken"}, 64'(sat_bus.br_taken), 64'(sat3(m_taken)));
    check_val({tag, "_err_ill"},   64'(bus.err_illegal_bf), 64'(m_err_ill));
    check_val({tag, "_err_to"},    64'(bus.err_timeout), 64'(m_err_to));
    check_val({tag, "_rpc"},       64'(bus.redirect_pc), 64'(m_pc));
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_stall"},    64'(bus.stall), 64'd0);
    check_val({tag, "_ready"},    64'(bus.br_ready), 64'd1);
    check_val({tag, "_resolve"},  64'(bus.resolve_valid), 64'd0);
    check_val({tag, "_redirect"}, 64'(bus.redirect_valid), 64'd0);
    check_val({tag, "_flush"},    64'(bus.flush), 64'd0);
    check_val({tag, "_bce_a"},    64'(bus.bce_a), 64'd0);
    check_val({tag, "_bce_b"},    64'(bus.bce_b), 64'd0);
    check_val({tag, "_bce_bf"},   64'(bus.bce_bf), 64'd0);
    check_stats(tag);
  endtask

  task automatic model_reset();
    m_total = 0; m_taken = 0; m_err_ill = 1'b0; m_err_to = 1'b0; m_pc = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Called while the DUT is idle; returns at the falling edge of the cycle in
  // which the branch is finished (pulse cycle, or first idle cycle after a
  // timeout or kill), so the next call lands back-to-back.
  task automatic run_branch(input string tag, input logic [3:0] bf,
                            input logic [31:0] pc, input logic [31:0] off,
                            input logic [31:0] a, input logic [31:0] b,
                            input int d_rs, input int d_rt, input int kill_cyc);
    logic        need_rt;
    logic        taken;
    logic        timeout;
    logic        killed;
    logic        pulse;
    logic [31:0] tgt;
    int          r;
    int          end_cyc;
    int          last;
    int          busy_to;

    need_rt = (bf == 4'b1000) || (bf == 4'b1010);
    r       = need_rt ? ((d_rs > d_rt) ? d_rs : d_rt) : d_rs;
    timeout = (r - 1) >= WAIT_LIMIT;
    end_cyc = timeout ? WAIT_LIMIT : r + 1;
    killed  = (kill_cyc >= 1) && (kill_cyc <= end_cyc);
    last    = killed ? kill_cyc + 1 : end_cyc + 1;
    busy_to = killed ? kill_cyc : end_cyc;
    pulse   = !killed && !timeout;
    taken   = eval_bc(bf, a, need_rt ? b : 32'd0);
    tgt     = pc + 32'd4 + (off << 2);
    if (pulse) exp_q.push_back({taken, tgt});

    bus.kill      = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_bf     = bf;
    bus.br_pc     = pc;
    bus.br_offset = off;
    bus.rs_ready  = 1'b0;
    bus.rt_ready  = 1'b0;
    #1;
    check_val({tag, "_accept_ready"}, 64'(bus.br_ready), 64'd1);
    @(posedge clk);
    for (int i = 1; i <= last; i++) begin
      #1;
      bus.br_valid = 1'b0;
      bus.br_bf    = 4'($urandom);
      bus.rs_ready = (i >= d_rs);
      bus.rt_ready = (i >= d_rt);
      bus.rs_val   = (i == r) ? a : $urandom;
      bus.rt_val   = (i == r) ? b : $urandom;
      bus.kill     = (i == kill_cyc);
      @(negedge clk);
      check_val({tag, "_stall"},   64'(bus.stall), 64'(i <= busy_to));
      check_val({tag, "_resolve"}, 64'(bus.resolve_valid), 64'(pulse && (i == last)));
      if (killed && (i == kill_cyc))
        check_val({tag, "_kill_ready"}, 64'(bus.br_ready), 64'd0);
      if (i == last) begin
        if (pulse) begin
          m_total++;
          if (taken) begin
            m_taken++;
            m_pc = tgt;
          end
          check_val({tag, "_bce_a"}, 64'(bus.bce_a), 64'(a));
          check_val({tag, "_bce_b"}, 64'(bus.bce_b), 64'(need_rt ? b : 32'd0));
        end
        if (timeout && !killed) m_err_to = 1'b1;
        check_stats(tag);
      end else begin
        @(posedge clk);
      end
    end
    bus.kill = 1'b0;
  endtask

  task automatic run_illegal(input string tag, input logic [3:0] bf);
    bus.kill      = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_bf     = bf;
    bus.br_pc     = $urandom;
    bus.br_offset = $urandom;
    bus.rs_ready  = 1'b1;
    bus.rt_ready  = 1'b1;
    #1;
    check_val({tag, "_accept_ready"}, 64'(bus.br_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.br_valid = 1'b0;
    bus.rs_ready = 1'b0;
    bus.rt_ready = 1'b0;
    m_err_ill = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_val({tag, "_resolve"}, 64'(bus.resolve_valid), 64'd0);
    end
    check_stats(tag);
  endtask

  task automatic run_mid_reset();
    bus.kill     = 1'b0;
    bus.br_valid = 1'b1;
    bus.br_bf    = 4'b1000;
    bus.br_pc    = 32'h1234_5678;
    bus.rs_ready = 1'b0;
    bus.rt_ready = 1'b0;
    @(posedge clk);
    #1 bus.br_valid = 1'b0;
    @(negedge clk);
    check_val("midrst_stall_before", 64'(bus.stall), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state("midrst");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0]  bf;
    logic [31:0] a;
    logic [31:0] b;
    int          d_rs;
    int          d_rt;
    int          kc;

    n_vec = 0;
    n_err = 0;
    model_reset();
    rst           = 1'b1;
    bus.br_valid  = 1'b0;
    bus.br_bf     = '0;
    bus.br_pc     = '0;
    bus.br_offset = '0;
    bus.rs_val    = '0;
    bus.rt_val    = '0;
    bus.rs_ready  = 1'b0;
    bus.rt_ready  = 1'b0;
    bus.kill      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    run_branch("taken_beq", 4'b1000, 32'h0040_0010, 32'h0000_0003, 32'd5, 32'd5, 1, 1, 0);
    check_val("taken_beq_target", 64'(bus.redirect_pc), 64'h0040_0020);
    run_branch("nt_bgtz", 4'b1110, 32'h0000_0100, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7, 1, 1, 0);
    run_branch("stall_bne", 4'b1010, 32'h0000_2000, 32'h0000_0010, 32'd1, 32'd2, 1, 5, 0);
    run_branch("timeout", 4'b1100, 32'h0000_3000, 32'h0000_0004, 32'd0, 32'd0, 21, 1, 0);
    run_illegal("illegal", 4'b0101);
    run_branch("kill_eval", 4'b1000, 32'h0000_4000, 32'h0000_0008, 32'd9, 32'd9, 1, 1, 2);
    run_branch("b2b_first", 4'b0011, 32'h0000_5000, 32'h0000_0001, 32'd3, 32'd0, 1, 1, 0);
    run_branch("b2b_second", 4'b0010, 32'h0000_6000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2, 1, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_illegal("rnd_illegal", illegal_bf[$urandom_range(0, 9)]);
      end else begin
        bf   = legal_bf[$urandom_range(0, 5)];
        a    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        b    = ($urandom_range(0, 1) == 0) ? a : $urandom;
        d_rs = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 4);
        d_rt = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 4);
        kc   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
        run_branch("rnd", bf, $urandom, $urandom, a, b, d_rs, d_rt, kc);
      end
    end

    run_mid_reset();
    for (int n = 0; n < 5; n++)
      run_branch("sat", 4'b1000, 32'h0000_7000 + 32'(n), 32'h0000_0002, 32'd4, 32'd4, 1, 1, 0);
    check_val("sat_total_final", 64'(sat_bus.br_total), 64'd3);
    check_val("sat_taken_final", 64'(sat_bus.br_taken), 64'd3);
    check_val("full_total_final", 64'(bus.br_total), 64'd5);

    @(negedge clk);
    check_val("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

endmodule
